// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch sequencer.
// FETCH_MISALIGN_TRAP_EN adds the HALT state used by the misaligned-redirect trap.
package fetch_pkg;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {
        ST_BOOT, ST_REQ, ST_WAIT, ST_DROP, ST_HOLD, ST_HALT
    } fetch_state_t;
`else
    typedef enum logic [2:0] {
        ST_BOOT, ST_REQ, ST_WAIT, ST_DROP, ST_HOLD
    } fetch_state_t;
`endif

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: drives the external PC, the imem handshake and the IF/ID slot.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects raise a sticky flag and halt fetching.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        PC_Write,
    output logic [31:0] next_pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);

    fetch_state_t state_q, state_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic         pc_write;
    logic [31:0]  pc_load;
    logic         req;
    logic [31:0]  redir_tgt;
    logic [31:0]  pc_plus4;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic         misalign_q, misalign_d;
    logic         redir_bad;

    assign redir_tgt = redirect_pc;
    assign redir_bad = |redirect_pc[1:0];
`else
    // Without the trap the low bits are simply dropped so the PC stays word aligned.
    assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

    assign pc_plus4 = pc + PC_STEP;

    always_comb begin
        state_d    = state_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        pc_write   = 1'b0;
        pc_load    = RESET_VECTOR;
        req        = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            ST_BOOT: begin
                pc_write = 1'b1;
                pc_load  = RESET_VECTOR;
                state_d  = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_write = 1'b1;
                    pc_load  = redir_tgt;
                end else begin
                    req = !stall;
                    if (!stall && imem_gnt) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_write = 1'b1;
                    pc_load  = redir_tgt;
                    state_d  = imem_rvalid ? ST_REQ : ST_DROP;
                end else if (imem_rvalid) begin
                    if_instr_d = imem_rdata;
                    if_pc_d    = pc;
                    pc_write   = 1'b1;
                    pc_load    = pc_plus4;
                    state_d    = ST_HOLD;
                end
            end
            ST_DROP: begin
                // The stale response is swallowed; only its arrival matters.
                if (redirect_valid) begin
                    pc_write = 1'b1;
                    pc_load  = redir_tgt;
                end
                if (imem_rvalid) state_d = ST_REQ;
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_write = 1'b1;
                    pc_load  = redir_tgt;
                    state_d  = ST_REQ;
                end else if (if_ready && !stall) begin
                    state_d = ST_REQ;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: state_d = ST_BOOT;
        endcase

`ifdef FETCH_MISALIGN_TRAP_EN
        // A misaligned target overrides whatever the state wanted to do with the redirect.
        if (redirect_valid && redir_bad && state_q != ST_BOOT && state_q != ST_HALT) begin
            state_d    = ST_HALT;
            pc_write   = 1'b0;
            pc_load    = RESET_VECTOR;
            req        = 1'b0;
            if_instr_d = if_instr_q;
            if_pc_d    = if_pc_q;
            misalign_d = 1'b1;
        end
`endif
        if_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            if_valid_q <= 1'b0;
            if_instr_q <= INSTR_NOP;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end

    assign fetch_misalign = misalign_q;
`endif

    // BOOT would otherwise decode a PC load while reset is still held.
    assign PC_Write  = pc_write & ~rst;
    assign next_pc   = pc_load;
    assign imem_req  = req & ~rst;
    assign imem_addr = pc;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: external PC register, imem responder and
// a queue of expected (pc, instr) pairs checked whenever decode consumes an instruction.
module tb_fetch_controller;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        PC_Write;
    logic [31:0] next_pc;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    int          n_assert = 0;
    int          n_fail   = 0;
    int          consumed = 0;
    logic [31:0] exp_q[$];

    logic        gnt_en;
    int          rsp_lat;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;

    fetch_controller #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .rst(rst), .pc(pc), .PC_Write(PC_Write), .next_pc(next_pc),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .fetch_misalign(fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    // External program counter
    always @(posedge clk or posedge rst) begin
        if (rst)           pc <= 32'h0;
        else if (PC_Write) pc <= next_pc;
    end

    // Instruction memory: grant gated by gnt_en, response rsp_lat wait cycles later
    assign imem_gnt = imem_req & gnt_en;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
            pend        <= 1'b0;
            cnt         <= 0;
            paddr       <= 32'h0;
        end else begin
            imem_rvalid <= 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_f(paddr);
                    pend        <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (imem_req && imem_gnt) begin
                if (rsp_lat == 0) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_f(imem_addr);
                end else begin
                    pend  <= 1'b1;
                    cnt   <= rsp_lat;
                    paddr <= imem_addr;
                end
            end
        end
    end

    // Scoreboard: pop one expectation per consumed instruction
    always @(negedge clk) begin
        if (!rst && imem_req) begin
            n_assert++;
            if (pend) begin
                n_fail++;
                $display("FAIL one_outstanding: imem_req=1 while a response is pending (addr %h)", imem_addr);
            end
        end
        if (!rst && if_valid && if_ready && !stall && !redirect_valid) begin
            consumed++;
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_instr: if_pc=%h if_instr=%h, no instruction expected", if_pc, if_instr);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (if_pc !== e) begin
                    n_fail++;
                    $display("FAIL sb_pc: got %h expected %h", if_pc, e);
                end
                n_assert++;
                if (if_instr !== mem_f(e)) begin
                    n_fail++;
                    $display("FAIL sb_instr: got %h expected %h", if_instr, mem_f(e));
                end
            end
        end
    end

    task automatic assert_rst();
        @(posedge clk); #1;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        if_ready = 1'b0; gnt_en = 1'b1; rsp_lat = 0;
        exp_q.delete();
        consumed = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        rst = 1'b0;
    endtask

    task automatic do_reset();
        assert_rst();
        release_rst();
    endtask

    task automatic wait_consumed(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (consumed >= n) break;
        end
        n_assert++;
        if (consumed < n) begin
            n_fail++;
            $display("FAIL consume_timeout: consumed %0d expected %0d", consumed, n);
        end
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (if_valid) break;
        end
        n_assert++;
        if (!if_valid) begin
            n_fail++;
            $display("FAIL valid_timeout: if_valid=%b expected 1", if_valid);
        end
    endtask

    task automatic test_reset();
        assert_rst();
        @(negedge clk);
        n_assert++; if (if_valid !== 1'b0)      begin n_fail++; $display("FAIL rst_if_valid: got %b expected 0", if_valid); end
        n_assert++; if (if_instr !== 32'h13)    begin n_fail++; $display("FAIL rst_if_instr: got %h expected 00000013", if_instr); end
        n_assert++; if (if_pc !== 32'h0)        begin n_fail++; $display("FAIL rst_if_pc: got %h expected 0", if_pc); end
        n_assert++; if (imem_req !== 1'b0)      begin n_fail++; $display("FAIL rst_imem_req: got %b expected 0", imem_req); end
        n_assert++; if (PC_Write !== 1'b0)      begin n_fail++; $display("FAIL rst_pc_write: got %b expected 0", PC_Write); end
        n_assert++; if (next_pc !== RV)         begin n_fail++; $display("FAIL rst_next_pc: got %h expected %h", next_pc, RV); end
`ifdef FETCH_MISALIGN_TRAP_EN
        n_assert++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b expected 0", fetch_misalign); end
`endif
        @(posedge clk); #1;
        release_rst();
        @(negedge clk);
        n_assert++; if (PC_Write !== 1'b1 || next_pc !== RV) begin
            n_fail++; $display("FAIL boot_pc_load: PC_Write=%b next_pc=%h expected 1/%h", PC_Write, next_pc, RV);
        end
        @(negedge clk);
        n_assert++; if (imem_req !== 1'b1 || imem_addr !== RV) begin
            n_fail++; $display("FAIL first_req: imem_req=%b imem_addr=%h expected 1/%h", imem_req, imem_addr, RV);
        end
        @(negedge clk);
        n_assert++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid: got %b expected 0", if_valid); end
        @(negedge clk);
        n_assert++; if (if_valid !== 1'b1 || if_pc !== RV) begin
            n_fail++; $display("FAIL first_valid_cycle4: if_valid=%b if_pc=%h expected 1/%h", if_valid, if_pc, RV);
        end
        @(posedge clk); #1;
        exp_q.push_back(RV);
        if_ready = 1'b1;
        wait_consumed(1, 20);
        if_ready = 1'b0;
        @(negedge clk);
        n_assert++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL valid_drop: got %b expected 0", if_valid); end
    endtask

    task automatic test_sequential();
        do_reset();
        exp_q.push_back(RV);
        exp_q.push_back(RV + 32'd4);
        exp_q.push_back(RV + 32'd8);
        if_ready = 1'b1;
        wait_consumed(3, 40);
        if_ready = 1'b0;
        n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL seq_left: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_gnt_hold();
        do_reset();
        @(posedge clk); #1;
        stall = 1'b1; gnt_en = 1'b0;
        @(negedge clk);
        n_assert++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %b expected 0", imem_req); end
        @(posedge clk); #1;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_assert++;
            if (imem_req !== 1'b1 || imem_addr !== RV) begin
                n_fail++; $display("FAIL gnt_hold_addr: imem_req=%b imem_addr=%h expected 1/%h", imem_req, imem_addr, RV);
            end
            @(posedge clk); #1;
        end
        gnt_en = 1'b1;
        exp_q.push_back(RV);
        if_ready = 1'b1;
        wait_consumed(1, 20);
        if_ready = 1'b0; gnt_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_assert++;
            if (if_valid !== 1'b0) begin n_fail++; $display("FAIL single_instr: if_valid=%b expected 0", if_valid); end
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        rsp_lat = 2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) break;
        end
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        n_assert++; if (imem_req !== 1'b0 || pc !== 32'h200) begin
            n_fail++; $display("FAIL drop_state: imem_req=%b pc=%h expected 0/00000200", imem_req, pc);
        end
        exp_q.push_back(32'h200);
        if_ready = 1'b1;
        wait_consumed(1, 30);
        if_ready = 1'b0;
    endtask

    task automatic test_hold_stall();
        do_reset();
        wait_valid(20);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i >= 4) begin if_ready = 1'b1; stall = 1'b1; end
            @(negedge clk);
            n_assert++;
            if (if_valid !== 1'b1 || if_pc !== RV || if_instr !== mem_f(RV) ||
                imem_req !== 1'b0 || PC_Write !== 1'b0 || pc !== RV + 32'd4) begin
                n_fail++;
                $display("FAIL hold_stable: valid=%b if_pc=%h instr=%h req=%b pcw=%b pc=%h expected 1/%h/%h/0/0/%h",
                         if_valid, if_pc, if_instr, imem_req, PC_Write, pc, RV, mem_f(RV), RV + 32'd4);
            end
        end
        n_assert++; if (consumed != 0) begin n_fail++; $display("FAIL hold_consumed: got %0d expected 0", consumed); end
        @(posedge clk); #1;
        stall = 1'b0;
        exp_q.push_back(RV);
        exp_q.push_back(RV + 32'd4);
        wait_consumed(2, 30);
        if_ready = 1'b0;
    endtask

    task automatic test_redirect_hold();
        int c0;
        do_reset();
        wait_valid(20);
        c0 = consumed;
        @(posedge clk); #1;
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        n_assert++; if (if_valid !== 1'b0 || consumed != c0) begin
            n_fail++; $display("FAIL flush: if_valid=%b consumed=%0d expected 0/%0d", if_valid, consumed, c0);
        end
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        wait_consumed(c0 + 2, 40);
        if_ready = 1'b0;
    endtask

    task automatic test_misalign();
        do_reset();
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h202;
        @(negedge clk);
        n_assert++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redirect_req: got %b expected 0", imem_req); end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_assert++;
            if (fetch_misalign !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0 || PC_Write !== 1'b0) begin
                n_fail++; $display("FAIL halt: misalign=%b req=%b valid=%b pcw=%b expected 1/0/0/0",
                                   fetch_misalign, imem_req, if_valid, PC_Write);
            end
        end
        assert_rst();
        @(negedge clk);
        n_assert++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %b expected 0", fetch_misalign); end
        release_rst();
`else
        exp_q.push_back(32'h200);
        if_ready = 1'b1;
        wait_consumed(1, 30);
        if_ready = 1'b0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        if_ready = 1'b0; gnt_en = 1'b1; rsp_lat = 0;
        test_reset();
        test_sequential();
        test_gnt_hold();
        test_redirect_wait();
        test_hold_stall();
        test_redirect_hold();
        test_misalign();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the RV32I instruction-fetch stage. Owns the program counter's `PC_Write`/`next_pc` inputs and runs the instruction-memory request/response handshake. Presents fetched instructions to the IF/ID boundary with a valid/ready handshake. Applies stalls from the hazard unit and redirects from branch/jump resolution, including discarding in-flight stale fetches.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  32  current PC from the program counter.
- `PC_Write`  out  1  PC load enable.
- `next_pc`  out  32  PC load value.
- `stall`  in  1  hazard unit: do not issue a new fetch.
- `redirect_valid`  in  1  taken branch/jump/trap this cycle.
- `redirect_pc`  in  32  redirect target.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  32  request address.
- `imem_gnt`  in  1  request accepted. Counts only while `imem_req`=1.
- `imem_rvalid`  in  1  response valid. Arrives at least 1 cycle after grant; one response per grant.
- `imem_rdata`  in  32  response instruction.
- `if_valid`  out  1  fetched instruction available.
- `if_instr`  out  32  fetched instruction.
- `if_pc`  out  32  address of `if_instr`.
- `if_ready`  in  1  decode accepts the instruction.
- `fetch_misalign`  out  1  sticky misaligned-redirect flag. Exists only with the macro.

## Operation
- States: BOOT, REQ, WAIT, DROP, HOLD, HALT (HALT only with the macro).
- **BOOT** (entered on reset):
  - `PC_Write`=1, `next_pc`=RESET_VECTOR.
  - Next state is REQ.
- **REQ:**
  - `imem_req`=!stall && !redirect_valid; `imem_addr`=pc.
  - The address is held stable while `imem_req`=1 and `imem_gnt`=0.
  - On grant, go to WAIT.
  - On redirect_valid: `PC_Write`=1, `next_pc`=redirect_pc; stay in REQ.
- **WAIT:**
  - `imem_rvalid` with no redirect:
    - Capture `if_instr`=imem_rdata and `if_pc`=pc.
    - `PC_Write`=1, `next_pc`=pc+4 (mod 2^32).
    - Go to HOLD.
  - `imem_rvalid` with redirect in the same cycle: discard the response, load redirect_pc, go to REQ.
  - Redirect without rvalid: load redirect_pc, go to DROP.
- **DROP:**
  - Wait for `imem_rvalid` and discard the response, then go to REQ.
  - A further redirect reloads the PC and stays in DROP.
- **HOLD:**
  - `if_valid`=1.
  - `if_ready` && !stall consumes the instruction; go to REQ.
  - Redirect has priority over consumption: flush (`if_valid` low the next cycle), load redirect_pc, go to REQ.
- Priority: rst > redirect_valid > stall > normal progress.
- `PC_Write`=0 in every cycle and state not listed above.
- All outputs are registered except `imem_req`, `imem_addr`, `PC_Write` and `next_pc`, which are Moore/Mealy decodes of state and the inputs.

## Timing
- Reset values:
  - State: BOOT.
  - `if_valid`=0, `if_instr`=32'h0000_0013 (NOP), `if_pc`=0.
  - `imem_req`=0, `PC_Write`=0, `next_pc`=RESET_VECTOR, `fetch_misalign`=0.
- Reset asserted mid-fetch abandons any outstanding response. The memory side is reset by the same `rst`.
- Minimum per-instruction latency with zero-wait memory:
  - REQ (grant) → WAIT (rvalid) → HOLD (consumed), i.e. 3 cycles.
  - First `if_valid` 4 cycles after reset release, counting BOOT.
- `if_valid` drops in the cycle after consumption or flush. `if_instr`/`if_pc` are stable while `if_valid`=1.
- At most one outstanding request. No new request is issued until the prior response is received or dropped.

## Configuration
- With `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with redirect_pc[1:0]≠0 sets `fetch_misalign`=1 (sticky until reset) and enters HALT.
  - HALT: no requests, `if_valid`=0, `PC_Write`=0, until reset.
  - If a request was outstanding, its response is still consumed and discarded.
- Without the macro:
  - redirect_pc[1:0] is forced to 00 before the PC is loaded.
  - `fetch_misalign` is not present.

## Structure
- Shared package `fetch_pkg` contains:
  - `fetch_state_t` enum.
  - `INSTR_NOP` = 32'h0000_0013.
  - `PC_STEP` = 4.
- No sub-module: the PC register is the external program counter, and the +4 adder and decode are inline.

## Test plan
- Reset release with RESET_VECTOR=32'h100 and zero-wait memory → `PC_Write`/`next_pc`=0x100 in cycle 1; fetches at 0x100, 0x104, 0x108 presented in order with matching `if_pc`.
- Grant held low for 3 cycles → `imem_addr` stays constant; after grant, exactly one `if_valid` instruction.
- Redirect to 0x200 while in WAIT, response arriving 2 cycles later → response discarded; next `if_pc`=0x200.
- `if_ready`=0 for 4 cycles in HOLD, plus `stall`=1 for 2 cycles → `if_valid` and `if_instr` held; no `imem_req`; PC unchanged.
- Redirect in the same cycle as `if_ready`=1 in HOLD → instruction flushed, not counted; next fetch from the redirect target.
- Macro defined, redirect to 0x202 → `fetch_misalign`=1, `imem_req` stays 0 until `rst`. Without the macro → fetch from 0x200.
